hazard_unit_mc: RTL and testbench
=================================

Name: hazard_unit_mc

Overview:
- Clocked, parametrised hazard detection unit for the 5-stage MIPS pipeline. Sits between the IF/ID and ID/EX registers.
- Detects load-use and branch-in-ID data hazards against both the ID/EX and EX/MEM stages, with a configurable load latency.
- Owns a stall-length down-counter FSM, so multi-cycle stalls come from one detection event rather than from combinational glitch memory.
- Produces stall/bubble controls and saturating performance counters.

Parameters:
- REG_AW, 5, register address width.
- MEM_LAT, 1, data-memory load latency in cycles, legal range 1..7.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_rs  in  REG_AW  source reg A of the instruction in ID
- id_rt  in  REG_AW  source reg B of the instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_branch  in  1  ID instruction is a branch resolved in ID
- ex_rd  in  REG_AW  destination in ID/EX
- ex_mem_read  in  1  ID/EX holds a load
- ex_reg_write  in  1  ID/EX writes a register
- mem_rd  in  REG_AW  destination in EX/MEM
- mem_mem_read  in  1  EX/MEM holds a load
- mem_reg_write  in  1  EX/MEM writes a register
- flush  in  1  pipeline flush (taken branch or exception)
- stall  out  1  hold PC and IF/ID
- bubble  out  1  zero ID/EX control fields this cycle
- stall_cycles  out  CNT_W  total stalled cycles
- hazard_events  out  CNT_W  number of detection events

Behaviour:
- Matching rules:
  - match_ex = ex_reg_write && ex_rd != 0 && ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd)).
  - match_mem is the same expression using the mem_* inputs.
  - Register 0 never matches.
- Required stall length N, evaluated only in IDLE, first true rule wins:
  1. id_branch && match_ex && ex_mem_read: N = MEM_LAT+1.
  2. id_branch && match_ex: N = 1.
  3. id_branch && match_mem && mem_mem_read: N = MEM_LAT.
  4. !id_branch && match_ex && ex_mem_read: N = MEM_LAT.
  5. Otherwise: no hazard. This includes a non-branch ALU producer and a branch with an ALU producer in MEM; both are covered by forwarding.
- FSM states: IDLE, STALL. Down-counter cnt has width clog2(MEM_LAT+2).
- IDLE with a hazard:
  - stall = bubble = 1 in the same cycle (combinational).
  - hazard_events increments.
  - If N > 1: cnt <= N-1 and go to STALL. If N == 1: stay in IDLE and re-evaluate next cycle.
- STALL:
  - stall = bubble = 1; inputs are not re-evaluated.
  - cnt decrements each cycle. At cnt == 1, return to IDLE next cycle.
  - Re-evaluation in IDLE then catches any residual hazard.
- stall_cycles increments every cycle stall = 1 and saturates at all-ones. hazard_events also saturates.
- flush = 1:
  - Forces stall = bubble = 0 that cycle, state <= IDLE, cnt <= 0.
  - No event is counted, even if a hazard is present.
  - flush wins over any simultaneous hazard.
- Reset (rst_n = 0 at a clk edge): state IDLE, cnt 0, both counters 0. While rst_n = 0, stall = bubble = 0 combinationally.
- Reset mid-stall aborts the stall immediately.
- No X propagation: with no hazard, stall = bubble = 0 regardless of the id_use_* and don't-care fields.

Decomposition:
- Shared package pipe_pkg holds:
  - the state enum {IDLE, STALL}
  - REG_ZERO constant
  - a function computing the counter width from MEM_LAT
- Natural sub-module: hazard_match, a purely combinational comparator instantiated twice (EX and MEM) that outputs match_* for the given rd/write/use inputs.
- The FSM and counters stay in the top module.

Test Plan:
- Load-use, MEM_LAT=1: lw r5 in EX, add using rs=5 in ID -> stall = 1 for exactly 1 cycle, hazard_events = 1, stall_cycles = 1.
- Branch on load, MEM_LAT=2: lw r7 in EX, beq rt=7 in ID -> stall for 3 consecutive cycles; no second event counted; stall = 0 in cycle 4.
- Branch on ALU result: add r3 in EX, beq rs=3 -> 1 stall cycle. Same case with r3 in MEM and no load -> no stall.
- r0 immunity: lw r0 in EX, use rs=0 -> stall = 0, counters unchanged.
- Flush mid-stall, MEM_LAT=3: branch-on-load stall begins, flush asserted in stall cycle 2 -> stall = 0 that cycle, IDLE next, stall_cycles = 1.
- Reset mid-stall plus saturation: rst_n = 0 during STALL -> stall = 0 and counters = 0 next edge. Counter preloaded near max with CNT_W=4: after 20 stall cycles stall_cycles = 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard logic.
package pipe_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_e;

    localparam int unsigned REG_ZERO = 0;

    // Down-counter width: must hold MEM_LAT+1, the longest stall length.
    function automatic int unsigned cnt_width(input int unsigned mem_lat);
        return $clog2(mem_lat + 2);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares the ID-stage source registers against one producer stage's destination.
module hazard_match #(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rd,
    input  logic              reg_write,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic              use_rs,
    input  logic              use_rt,
    output logic              match
);
    import pipe_pkg::*;

    // Register 0 is hardwired, so it is never a real dependency.
    always_comb begin
        match = 1'b0;
        if (reg_write && (rd != REG_AW'(REG_ZERO))) begin
            match = (use_rs && (rs == rd)) || (use_rt && (rt == rd));
        end
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// Load-use / branch-in-ID hazard detection with a stall-length down-counter
// and saturating performance counters.
module hazard_unit_mc #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_branch,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_mem_read,
    input  logic              mem_reg_write,
    input  logic              flush,
    output logic              stall,
    output logic              bubble,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  hazard_events
);
    import pipe_pkg::*;

    localparam int unsigned CW = cnt_width(MEM_LAT);

    state_e        state;
    state_e        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          match_ex;
    logic          match_mem;
    logic          hazard;
    logic [CW-1:0] need;
    logic          detect;

    hazard_match #(.REG_AW(REG_AW)) u_match_ex (
        .rd        (ex_rd),
        .reg_write (ex_reg_write),
        .rs        (id_rs),
        .rt        (id_rt),
        .use_rs    (id_use_rs),
        .use_rt    (id_use_rt),
        .match     (match_ex)
    );

    hazard_match #(.REG_AW(REG_AW)) u_match_mem (
        .rd        (mem_rd),
        .reg_write (mem_reg_write),
        .rs        (id_rs),
        .rt        (id_rt),
        .use_rs    (id_use_rs),
        .use_rt    (id_use_rt),
        .match     (match_mem)
    );

    // Required stall length; ALU producers not listed here are forwarded.
    always_comb begin
        hazard = 1'b0;
        need   = '0;
        if (id_branch && match_ex && ex_mem_read) begin
            hazard = 1'b1;
            need   = CW'(MEM_LAT + 1);
        end else if (id_branch && match_ex) begin
            hazard = 1'b1;
            need   = CW'(1);
        end else if (id_branch && match_mem && mem_mem_read) begin
            hazard = 1'b1;
            need   = CW'(MEM_LAT);
        end else if (!id_branch && match_ex && ex_mem_read) begin
            hazard = 1'b1;
            need   = CW'(MEM_LAT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Single-cycle stalls stay in IDLE so the next cycle is re-evaluated.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hazard && (need > CW'(1))) begin
                        state_nxt = STALL;
                        cnt_nxt   = need - CW'(1);
                    end
                end
                STALL: begin
                    if (cnt <= CW'(1)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Reset and flush both mask the stall controls in the same cycle.
    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        detect = 1'b0;
        if (rst_n && !flush) begin
            unique case (state)
                IDLE: begin
                    if (hazard) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                        detect = 1'b1;
                    end
                end
                STALL: begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end
                default: begin
                    stall  = 1'b0;
                    bubble = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles  <= '0;
            hazard_events <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (detect && (hazard_events != '1)) begin
                hazard_events <= hazard_events + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Drives three hazard units (MEM_LAT 1/2/3, the last with 4-bit counters)
// from shared inputs and scores stall/bubble per cycle plus the counters.
module tb_hazard_unit_mc;

    typedef struct {
        logic       branch;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic [4:0] ex_rd;
        logic       ex_mr;
        logic       ex_rw;
        logic [4:0] mem_rd;
        logic       mem_mr;
        logic       mem_rw;
        logic       flush;
        logic       rst_n;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_use_rs = 1'b0;
    logic        id_use_rt = 1'b0;
    logic        id_branch = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        ex_mem_read = 1'b0;
    logic        ex_reg_write = 1'b0;
    logic [4:0]  mem_rd = '0;
    logic        mem_mem_read = 1'b0;
    logic        mem_reg_write = 1'b0;
    logic        flush = 1'b0;

    logic        stall1, stall2, stall3;
    logic        bubble1, bubble2, bubble3;
    logic [31:0] sc1, ev1, sc2, ev2;
    logic [3:0]  sc3, ev3;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [2:0]  sb[$];

    always #5 clk = ~clk;

    hazard_unit_mc #(.REG_AW(5), .MEM_LAT(1), .CNT_W(32)) u1 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .mem_rd(mem_rd), .mem_mem_read(mem_mem_read), .mem_reg_write(mem_reg_write),
        .flush(flush), .stall(stall1), .bubble(bubble1),
        .stall_cycles(sc1), .hazard_events(ev1)
    );

    hazard_unit_mc #(.REG_AW(5), .MEM_LAT(2), .CNT_W(32)) u2 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .mem_rd(mem_rd), .mem_mem_read(mem_mem_read), .mem_reg_write(mem_reg_write),
        .flush(flush), .stall(stall2), .bubble(bubble2),
        .stall_cycles(sc2), .hazard_events(ev2)
    );

    hazard_unit_mc #(.REG_AW(5), .MEM_LAT(3), .CNT_W(4)) u3 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .mem_rd(mem_rd), .mem_mem_read(mem_mem_read), .mem_reg_write(mem_reg_write),
        .flush(flush), .stall(stall3), .bubble(bubble3),
        .stall_cycles(sc3), .hazard_events(ev3)
    );

    function automatic stim_t mk(input logic br, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic urs, input logic urt,
                                 input logic [4:0] erd, input logic emr, input logic erw,
                                 input logic [4:0] mrd, input logic mmr, input logic mrw,
                                 input logic fl, input logic rn);
        stim_t s;
        s.branch = br;  s.rs = rs;  s.rt = rt;  s.use_rs = urs;  s.use_rt = urt;
        s.ex_rd = erd;  s.ex_mr = emr;  s.ex_rw = erw;
        s.mem_rd = mrd; s.mem_mr = mmr; s.mem_rw = mrw;
        s.flush = fl;   s.rst_n = rn;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        id_branch = s.branch;  id_rs = s.rs;  id_rt = s.rt;
        id_use_rs = s.use_rs;  id_use_rt = s.use_rt;
        ex_rd = s.ex_rd;  ex_mem_read = s.ex_mr;  ex_reg_write = s.ex_rw;
        mem_rd = s.mem_rd; mem_mem_read = s.mem_mr; mem_reg_write = s.mem_rw;
        flush = s.flush;  rst_n = s.rst_n;
    endtask

    task automatic do_reset();
        @(negedge clk);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_reset();
        logic [2:0] e;
        // Hazard present while in reset: controls must stay low.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            apply(mk(0, 5, 1, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0));
            sb.push_back(3'b000);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({stall3, stall2, stall1} !== e || {bubble3, bubble2, bubble1} !== e) begin
                n_errors++;
                $display("FAIL reset cyc %0d stall=%b bubble=%b exp=%b", i, {stall3, stall2, stall1}, {bubble3, bubble2, bubble1}, e);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({sc1, ev1, sc2, ev2, sc3, ev3} !== {32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 4'd0}) begin
            n_errors++;
            $display("FAIL reset counters sc=%0d/%0d/%0d ev=%0d/%0d/%0d exp all 0", sc1, sc2, sc3, ev1, ev2, ev3);
        end
    endtask

    task automatic test_load_use();
        stim_t      st[$];
        logic [2:0] ex[$];
        logic [2:0] e;
        do_reset();
        st.push_back(mk(0, 5, 1, 1, 0, 5, 1, 1, 0, 0, 0, 0, 1)); ex.push_back(3'b111);
        st.push_back(mk(0, 5, 1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 1)); ex.push_back(3'b110);
        st.push_back(mk(0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(3'b100);
        st.push_back(mk(0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(3'b000);
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back(ex[i]);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({stall3, stall2, stall1} !== e || {bubble3, bubble2, bubble1} !== e) begin
                n_errors++;
                $display("FAIL load_use cyc %0d stall=%b bubble=%b exp=%b", i, {stall3, stall2, stall1}, {bubble3, bubble2, bubble1}, e);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({sc1, ev1, sc2, ev2, sc3, ev3} !== {32'd1, 32'd1, 32'd2, 32'd1, 4'd3, 4'd1}) begin
            n_errors++;
            $display("FAIL load_use counters sc=%0d/%0d/%0d ev=%0d/%0d/%0d exp sc=1/2/3 ev=1/1/1", sc1, sc2, sc3, ev1, ev2, ev3);
        end
    endtask

    task automatic test_branch_load();
        stim_t      st[$];
        logic [2:0] ex[$];
        logic [2:0] e;
        do_reset();
        st.push_back(mk(1, 2, 7, 0, 1, 7, 1, 1, 0, 0, 0, 0, 1)); ex.push_back(3'b111);
        st.push_back(mk(1, 2, 7, 0, 1, 0, 0, 0, 7, 1, 1, 0, 1)); ex.push_back(3'b111);
        st.push_back(mk(1, 2, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(3'b110);
        st.push_back(mk(1, 2, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(3'b100);
        st.push_back(mk(1, 2, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(3'b000);
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back(ex[i]);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({stall3, stall2, stall1} !== e || {bubble3, bubble2, bubble1} !== e) begin
                n_errors++;
                $display("FAIL branch_load cyc %0d stall=%b bubble=%b exp=%b", i, {stall3, stall2, stall1}, {bubble3, bubble2, bubble1}, e);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({sc1, ev1, sc2, ev2, sc3, ev3} !== {32'd2, 32'd1, 32'd3, 32'd1, 4'd4, 4'd1}) begin
            n_errors++;
            $display("FAIL branch_load counters sc=%0d/%0d/%0d ev=%0d/%0d/%0d exp sc=2/3/4 ev=1/1/1", sc1, sc2, sc3, ev1, ev2, ev3);
        end
    endtask

    task automatic test_branch_alu();
        stim_t      st[$];
        logic [2:0] ex[$];
        logic [2:0] e;
        do_reset();
        st.push_back(mk(1, 3, 4, 1, 1, 3, 0, 1, 0, 0, 0, 0, 1)); ex.push_back(3'b111);
        st.push_back(mk(1, 3, 4, 1, 1, 0, 0, 0, 3, 0, 1, 0, 1)); ex.push_back(3'b000);
        st.push_back(mk(1, 3, 4, 1, 1, 0, 0, 0, 3, 0, 1, 0, 1)); ex.push_back(3'b000);
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back(ex[i]);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({stall3, stall2, stall1} !== e || {bubble3, bubble2, bubble1} !== e) begin
                n_errors++;
                $display("FAIL branch_alu cyc %0d stall=%b bubble=%b exp=%b", i, {stall3, stall2, stall1}, {bubble3, bubble2, bubble1}, e);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({sc1, ev1, sc2, ev2, sc3, ev3} !== {32'd1, 32'd1, 32'd1, 32'd1, 4'd1, 4'd1}) begin
            n_errors++;
            $display("FAIL branch_alu counters sc=%0d/%0d/%0d ev=%0d/%0d/%0d exp sc=1/1/1 ev=1/1/1", sc1, sc2, sc3, ev1, ev2, ev3);
        end
    endtask

    task automatic test_branch_mem_load();
        stim_t      st[$];
        logic [2:0] ex[$];
        logic [2:0] e;
        do_reset();
        st.push_back(mk(1, 9, 4, 1, 1, 0, 0, 0, 9, 1, 1, 0, 1)); ex.push_back(3'b111);
        st.push_back(mk(1, 9, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(3'b110);
        st.push_back(mk(1, 9, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(3'b100);
        st.push_back(mk(1, 9, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(3'b000);
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back(ex[i]);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({stall3, stall2, stall1} !== e || {bubble3, bubble2, bubble1} !== e) begin
                n_errors++;
                $display("FAIL branch_mem_load cyc %0d stall=%b bubble=%b exp=%b", i, {stall3, stall2, stall1}, {bubble3, bubble2, bubble1}, e);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({sc1, ev1, sc2, ev2, sc3, ev3} !== {32'd1, 32'd1, 32'd2, 32'd1, 4'd3, 4'd1}) begin
            n_errors++;
            $display("FAIL branch_mem_load counters sc=%0d/%0d/%0d ev=%0d/%0d/%0d exp sc=1/2/3 ev=1/1/1", sc1, sc2, sc3, ev1, ev2, ev3);
        end
    endtask

    task automatic test_r0_and_x();
        stim_t      st[$];
        logic [2:0] ex[$];
        logic [2:0] e;
        do_reset();
        st.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1)); ex.push_back(3'b000);
        st.push_back(mk(1, 0, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1)); ex.push_back(3'b000);
        st.push_back(mk(0, 5'bx, 5'bx, 1'bx, 1'bx, 5, 1, 0, 5, 1, 0, 0, 1)); ex.push_back(3'b000);
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back(ex[i]);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({stall3, stall2, stall1} !== e || {bubble3, bubble2, bubble1} !== e) begin
                n_errors++;
                $display("FAIL r0_x cyc %0d stall=%b bubble=%b exp=%b", i, {stall3, stall2, stall1}, {bubble3, bubble2, bubble1}, e);
            end
        end
        @(negedge clk);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        n_checks++;
        if ({sc1, ev1, sc2, ev2, sc3, ev3} !== {32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 4'd0}) begin
            n_errors++;
            $display("FAIL r0_x counters sc=%0d/%0d/%0d ev=%0d/%0d/%0d exp all 0", sc1, sc2, sc3, ev1, ev2, ev3);
        end
    endtask

    task automatic test_flush();
        stim_t      st[$];
        logic [2:0] ex[$];
        logic [2:0] e;
        do_reset();
        st.push_back(mk(1, 2, 7, 0, 1, 7, 1, 1, 0, 0, 0, 0, 1)); ex.push_back(3'b111);
        st.push_back(mk(1, 2, 7, 0, 1, 7, 1, 1, 0, 0, 0, 1, 1)); ex.push_back(3'b000);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(3'b000);
        st.push_back(mk(0, 5, 1, 1, 0, 5, 1, 1, 0, 0, 0, 1, 1)); ex.push_back(3'b000);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(3'b000);
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back(ex[i]);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({stall3, stall2, stall1} !== e || {bubble3, bubble2, bubble1} !== e) begin
                n_errors++;
                $display("FAIL flush cyc %0d stall=%b bubble=%b exp=%b", i, {stall3, stall2, stall1}, {bubble3, bubble2, bubble1}, e);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({sc1, ev1, sc2, ev2, sc3, ev3} !== {32'd1, 32'd1, 32'd1, 32'd1, 4'd1, 4'd1}) begin
            n_errors++;
            $display("FAIL flush counters sc=%0d/%0d/%0d ev=%0d/%0d/%0d exp sc=1/1/1 ev=1/1/1", sc1, sc2, sc3, ev1, ev2, ev3);
        end
    endtask

    task automatic test_reset_mid_stall();
        stim_t      st[$];
        logic [2:0] ex[$];
        logic [2:0] e;
        do_reset();
        st.push_back(mk(1, 2, 7, 0, 1, 7, 1, 1, 0, 0, 0, 0, 1)); ex.push_back(3'b111);
        st.push_back(mk(1, 2, 7, 0, 1, 7, 1, 1, 0, 0, 0, 0, 0)); ex.push_back(3'b000);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(3'b000);
        foreach (st[i]) begin
            @(negedge clk);
            if (i == 2) begin
                n_checks++;
                if ({sc1, ev1, sc2, ev2, sc3, ev3} !== {32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 4'd0}) begin
                    n_errors++;
                    $display("FAIL reset_mid counters sc=%0d/%0d/%0d ev=%0d/%0d/%0d exp all 0", sc1, sc2, sc3, ev1, ev2, ev3);
                end
            end
            apply(st[i]);
            sb.push_back(ex[i]);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({stall3, stall2, stall1} !== e || {bubble3, bubble2, bubble1} !== e) begin
                n_errors++;
                $display("FAIL reset_mid cyc %0d stall=%b bubble=%b exp=%b", i, {stall3, stall2, stall1}, {bubble3, bubble2, bubble1}, e);
            end
        end
    endtask

    task automatic test_saturation();
        stim_t      st[$];
        logic [2:0] ex[$];
        logic [2:0] e;
        do_reset();
        for (int k = 0; k < 50; k++) begin
            st.push_back(mk(0, 5, 1, 1, 0, 5, 1, 1, 0, 0, 0, 0, 1)); ex.push_back(3'b111);
        end
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(3'b100);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(3'b000);
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back(ex[i]);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({stall3, stall2, stall1} !== e || {bubble3, bubble2, bubble1} !== e) begin
                n_errors++;
                $display("FAIL saturation cyc %0d stall=%b bubble=%b exp=%b", i, {stall3, stall2, stall1}, {bubble3, bubble2, bubble1}, e);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({sc1, ev1, sc2, ev2, sc3, ev3} !== {32'd50, 32'd50, 32'd50, 32'd25, 4'd15, 4'd15}) begin
            n_errors++;
            $display("FAIL saturation counters sc=%0d/%0d/%0d ev=%0d/%0d/%0d exp sc=50/50/15 ev=50/25/15", sc1, sc2, sc3, ev1, ev2, ev3);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_load();
        test_branch_alu();
        test_branch_mem_load();
        test_r0_and_x();
        test_flush();
        test_reset_mid_stall();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
